ifetch_seq: RTL and testbench
=============================

# ifetch_seq

Instruction-fetch sequencer between the instruction ROM and the CPU core.
- Replaces the manual boot address mux: drives the ROM address, fetching word 0 after reset and then following the core's `Addr`.
- Presents a registered, stable 21-bit instruction to the instruction decoder.
- Gates core execution with `core_en`, supporting free-run, pause, single-step and halt-on-zero-word.
- Counts retired instructions for bench and debug visibility.

## Interface
Parameters:
- `INS_W`, 21, instruction word width
- `ADDR_W`, 8, ROM address width
- `CNT_W`, 16, retired-instruction counter width

Ports:
- `CLK`  in  1  single system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted)
- `addr_cpu`  in  ADDR_W  next-instruction address from core `Addr` output
- `rom_data`  in  INS_W  combinational ROM read data for `rom_addr`
- `run`  in  1  level; 1 = free-run, 0 = pause
- `step`  in  1  level; each 0→1 transition while paused executes one instruction
- `rom_addr`  out  ADDR_W  ROM address
- `ins`  out  INS_W  registered instruction to decoder
- `core_en`  out  1  core may commit the instruction on `ins` at this edge
- `halted`  out  1  HALT state reached
- `retired`  out  CNT_W  count of edges with `core_en`=1, saturating

## Operation
- States: BOOT, RUN, PAUSE, HALT.
  - Reset (`reset`=0, async) forces BOOT.
  - Reset values: `ins`=0, `core_en`=0, `halted`=0, `retired`=0, `ins_valid`=0, step history=0.
- `rom_addr` is combinational:
  - In BOOT: 8'h00.
  - Otherwise: `addr_cpu`.
- BOOT:
  - On the first edge after reset release: `ins`←`rom_data`, `ins_valid`←1.
  - Next state is RUN if `run`=1, else PAUSE.
  - `core_en`=0 throughout BOOT.
- HALT word:
  - Defined as `INS_W'h0`.
  - `is_halt` = `ins_valid` & (`ins`==0).
- RUN:
  - `core_en` = ~`is_halt`.
  - On each edge with `core_en`=1: `ins`←`rom_data` and `retired`++.
  - If `is_halt`, next state is HALT.
  - Else if `run`=0 at the edge, next state is PAUSE. The instruction at that edge still commits.
- PAUSE:
  - `step_rise` = `step` & ~`step_d`, where `step_d` is `step` registered every cycle.
  - `core_en` = `step_rise` & ~`is_halt`.
  - On commit, behaves exactly as a RUN commit, then stays in PAUSE.
  - `run`=1 moves to RUN at the next edge. While `run`=1, `step_rise` is ignored (run wins).
  - `is_halt` moves to HALT.
- HALT:
  - `core_en`=0 and `halted`=1. `ins` and `retired` are frozen.
  - Leaves only via reset. `run`/`step` have no effect.
- `retired` saturates at all-ones and never wraps.
- Address wrap: `addr_cpu` 8'hFF→8'h00 is just another fetch, with no special handling.

## Timing
- Fetch latency is one edge: the `rom_data` for `rom_addr` in cycle n appears on `ins` after edge n.
- First `core_en`=1 is the cycle after BOOT completes, i.e. the second rising edge after reset release, when `run`=1.
- `core_en`, `halted` and `rom_addr` are combinational from registered state plus `run`/`step_d`/`step`. They have no dependency on `rom_data`.
- Halt is detected in the same cycle the zero word appears on `ins`. That word is never committed.
- Step pulse:
  - Exactly one commit per 0→1 `step` transition.
  - `step` held high gives no further commits.
  - `step` asserted high through reset release does not produce a step.
- Async reset mid-instruction:
  - All outputs go to reset values immediately.
  - The core sees `core_en`=0 with no partial commit.

## Structure
- Shared package `ifetch_pkg`:
  - state enum `ifetch_state_t` (BOOT=2'b00, RUN=2'b01, PAUSE=2'b10, HALT=2'b11)
  - `HALT_WORD` constant
  - default widths `INS_W`/`ADDR_W`/`CNT_W`
- Sub-module `edge_rise`:
  - registered 0→1 detector with async active-low reset
  - used for `step`
- Everything else stays in `ifetch_seq`: FSM, instruction register, saturating counter, address mux.

## Test plan
- Reset, `run`=1, ROM[0]=MOV R0,#5: `rom_addr`=0 in BOOT, `ins`=ROM[0] after edge 1, `core_en`=1 from cycle 2, `retired`=1 after edge 2.
- Free-run through ROM[0..3] with ROM[4]=0: `core_en` high for 4 commits, then `halted`=1, `core_en`=0, `retired`=4, `ins`=0 held for 20 cycles with `run` toggled.
- `run`=0 after BOOT, then 3 `step` pulses separated by 5 idle cycles: exactly 3 commits, `retired`=3, `ins` changes only on step edges; `step` held high 10 cycles gives 1 commit.
- `run` and `step` rising in the same PAUSE cycle: move to RUN, single commit per cycle, no extra commit; `run`→0 mid-stream gives PAUSE after the in-flight commit.
- Preload `retired`=16'hFFFE via long run loop (JMP #0 at ROM[0]): counter reaches 16'hFFFF and stays there.
- Assert `reset`=0 asynchronously between edges during RUN: `core_en`, `ins`, `retired`, `halted` go to 0 immediately; after release the BOOT sequence repeats from address 0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package ifetch_pkg;

  localparam int unsigned INS_W  = 21;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    StBoot  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10,
    StHalt  = 2'b11
  } ifetch_state_t;

  localparam logic [INS_W-1:0] HALT_WORD = '0;

endpackage

// File: rtl/edge_rise.sv
// Registered 0->1 detector: rise_o is high in the cycle d_i is 1 after a cycle at 0.
module edge_rise (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/ifetch_seq.sv
// Instruction-fetch sequencer: boots from word 0, gates core execution (run/pause/step/halt)
// and counts retired instructions.
module ifetch_seq
  import ifetch_pkg::*;
#(
  parameter int unsigned INS_W  = ifetch_pkg::INS_W,
  parameter int unsigned ADDR_W = ifetch_pkg::ADDR_W,
  parameter int unsigned CNT_W  = ifetch_pkg::CNT_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_cpu,
  input  logic [INS_W-1:0]  rom_data,
  input  logic              run,
  input  logic              step,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [INS_W-1:0]  ins,
  output logic              core_en,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  ifetch_state_t    state_q, state_d;
  logic [INS_W-1:0] ins_q, ins_d;
  logic             ins_valid_q, ins_valid_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             step_rise;
  logic             is_halt;

  edge_rise u_step_rise (
    .clk_i  (CLK),
    .rst_ni (reset),
    .d_i    (step),
    .rise_o (step_rise)
  );

  // ins_valid keeps the all-zero reset value of ins from looking like a halt word.
  assign is_halt = ins_valid_q && (ins_q == INS_W'(HALT_WORD));

  always_comb begin
    state_d     = state_q;
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q;
    retired_d   = retired_q;
    core_en     = 1'b0;
    halted      = 1'b0;
    rom_addr    = addr_cpu;

    unique case (state_q)
      StBoot: begin
        rom_addr    = '0;
        ins_d       = rom_data;
        ins_valid_d = 1'b1;
        state_d     = run ? StRun : StPause;
      end
      StRun: begin
        core_en = ~is_halt;
        if (is_halt) begin
          state_d = StHalt;
        end else if (!run) begin
          state_d = StPause;
        end
      end
      StPause: begin
        // run wins over a coincident step edge: no commit in the transition cycle.
        core_en = ~run & step_rise & ~is_halt;
        if (is_halt) begin
          state_d = StHalt;
        end else if (run) begin
          state_d = StRun;
        end
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: begin
        state_d = StBoot;
      end
    endcase

    if (core_en) begin
      ins_d = rom_data;
      if (retired_q != {CNT_W{1'b1}}) begin
        retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q     <= StBoot;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
      retired_q   <= retired_d;
    end
  end

  assign ins     = ins_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_ifetch_seq.sv
// Scoreboard bench for ifetch_seq: a small core model follows the committed stream and
// a monitor checks every committed instruction against the expected queue.
module tb_ifetch_seq;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  addr_cpu;
  logic [7:0]  rom_addr;
  logic [20:0] rom_data;
  logic [20:0] ins;
  logic        core_en;
  logic        halted;
  logic [15:0] retired;

  localparam logic [20:0] R0  = 21'h0A0005;  // MOV R0,#5
  localparam logic [20:0] R1  = 21'h0A1007;
  localparam logic [20:0] R2  = 21'h0C0102;
  localparam logic [20:0] R3  = 21'h100003;
  localparam logic [20:0] R4  = 21'h001234;
  localparam logic [20:0] R5  = 21'h0ABCDE;
  localparam logic [20:0] JMP0 = 21'h1F0000;

  logic [20:0] rom [256];
  logic [20:0] exp_w [6];
  logic [20:0] sb_q [$];
  logic [20:0] sb_exp;
  logic [7:0]  pc_q;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          sb_en = 1'b1;

  ifetch_seq dut (
    .CLK      (CLK),
    .reset    (reset),
    .addr_cpu (addr_cpu),
    .rom_data (rom_data),
    .run      (run),
    .step     (step),
    .rom_addr (rom_addr),
    .ins      (ins),
    .core_en  (core_en),
    .halted   (halted),
    .retired  (retired)
  );

  always #5 CLK = ~CLK;

  assign rom_data = rom[rom_addr];

  // Core model: pc_q is the address of ins; JMP (top bits 5'h1F) targets ins[7:0].
  assign addr_cpu = (ins[20:16] == 5'h1F) ? ins[7:0] : pc_q + 8'd1;

  always @(posedge CLK or negedge reset) begin
    if (!reset) pc_q <= 8'd0;
    else if (core_en) pc_q <= addr_cpu;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (reset === 1'b1 && sb_en && core_en === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL commit_unexpected: got commit of %h, expected none", ins);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("commit_ins", 32'(ins), 32'(sb_exp));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_main(input bit halt_at4);
    for (int i = 0; i < 256; i++) rom[i] = 21'h0;
    rom[0] = R0; rom[1] = R1; rom[2] = R2; rom[3] = R3;
    if (!halt_at4) begin
      rom[4] = R4;
      rom[5] = R5;
    end
  endtask

  // Leaves the bench in the BOOT cycle, just after reset release.
  task automatic do_reset(input logic run_v, input logic step_v);
    reset = 1'b0;
    run   = run_v;
    step  = step_v;
    repeat (2) tick();
    reset = 1'b1;
  endtask

  initial begin
    exp_w[0] = R0; exp_w[1] = R1; exp_w[2] = R2;
    exp_w[3] = R3; exp_w[4] = R4; exp_w[5] = R5;

    // Boot and free-run into a halt word at ROM[4]
    load_main(1'b1);
    do_reset(1'b1, 1'b0);
    chk("boot_rom_addr", 32'(rom_addr), 32'h0);
    chk("boot_core_en", 32'(core_en), 32'h0);
    chk("boot_ins", 32'(ins), 32'h0);
    chk("boot_retired", 32'(retired), 32'h0);
    chk("boot_halted", 32'(halted), 32'h0);
    sb_q.push_back(R0); sb_q.push_back(R1); sb_q.push_back(R2); sb_q.push_back(R3);
    tick();
    chk("ins_after_boot", 32'(ins), 32'(R0));
    chk("core_en_cycle2", 32'(core_en), 32'h1);
    tick();
    chk("retired_edge2", 32'(retired), 32'h1);
    repeat (5) tick();
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_core_en", 32'(core_en), 32'h0);
    chk("halt_retired", 32'(retired), 32'h4);
    chk("halt_ins", 32'(ins), 32'h0);
    for (int i = 0; i < 20; i++) begin
      run  = ~run;
      step = ~step;
      tick();
    end
    chk("halt_hold_halted", 32'(halted), 32'h1);
    chk("halt_hold_retired", 32'(retired), 32'h4);
    chk("halt_hold_ins", 32'(ins), 32'h0);
    chk("halt_sb_empty", 32'(sb_q.size()), 32'h0);

    // Single-step; step held through reset release must not count
    load_main(1'b0);
    do_reset(1'b0, 1'b1);
    tick();
    chk("pause_no_step_from_reset", 32'(core_en), 32'h0);
    step = 1'b0;
    tick();
    sb_q.push_back(R0); sb_q.push_back(R1); sb_q.push_back(R2);
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (5) tick();
      chk("step_ins", 32'(ins), 32'(exp_w[p+1]));
    end
    chk("step_retired3", 32'(retired), 32'h3);
    sb_q.push_back(R3);
    step = 1'b1;
    repeat (10) tick();
    step = 1'b0;
    tick();
    chk("step_held_retired", 32'(retired), 32'h4);
    chk("step_held_ins", 32'(ins), 32'(R4));
    chk("step_sb_empty", 32'(sb_q.size()), 32'h0);

    // run and step rise together in PAUSE, then run drops mid-stream
    load_main(1'b0);
    do_reset(1'b0, 1'b0);
    tick();
    run  = 1'b1;
    step = 1'b1;
    #1;
    chk("run_wins_core_en", 32'(core_en), 32'h0);
    tick();
    sb_q.push_back(R0); sb_q.push_back(R1); sb_q.push_back(R2); sb_q.push_back(R3);
    step = 1'b0;
    repeat (3) tick();
    run = 1'b0;
    #1;
    chk("inflight_core_en", 32'(core_en), 32'h1);
    tick();
    chk("paused_core_en", 32'(core_en), 32'h0);
    chk("paused_retired", 32'(retired), 32'h4);
    chk("paused_ins", 32'(ins), 32'(R4));
    tick();
    chk("paused_stays", 32'(core_en), 32'h0);
    chk("mix_sb_empty", 32'(sb_q.size()), 32'h0);

    // Counter saturation with JMP #0 looping on ROM[0]
    for (int i = 0; i < 256; i++) rom[i] = 21'h0;
    rom[0] = JMP0;
    do_reset(1'b1, 1'b0);
    sb_en = 1'b0;
    tick();
    repeat (65534) tick();
    chk("sat_fffe", 32'(retired), 32'hFFFE);
    tick();
    chk("sat_ffff", 32'(retired), 32'hFFFF);
    repeat (5) tick();
    chk("sat_hold", 32'(retired), 32'hFFFF);
    chk("sat_ins", 32'(ins), 32'(JMP0));
    sb_en = 1'b1;

    // Asynchronous reset between edges while running
    load_main(1'b0);
    do_reset(1'b1, 1'b0);
    sb_q.push_back(R0); sb_q.push_back(R1);
    repeat (3) tick();
    chk("pre_reset_core_en", 32'(core_en), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_core_en", 32'(core_en), 32'h0);
    chk("async_ins", 32'(ins), 32'h0);
    chk("async_retired", 32'(retired), 32'h0);
    chk("async_halted", 32'(halted), 32'h0);
    tick();
    reset = 1'b1;
    chk("reboot_rom_addr", 32'(rom_addr), 32'h0);
    chk("reboot_core_en", 32'(core_en), 32'h0);
    sb_q.push_back(R0);
    tick();
    chk("reboot_ins", 32'(ins), 32'(R0));
    tick();
    chk("reboot_retired", 32'(retired), 32'h1);
    chk("reboot_sb_empty", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
